// File: rtl/axi4_stream_upsizer_pkg.sv
// rtl/axi4_stream_upsizer_pkg.sv - shared types and helpers for the AXI4-Stream packing upsizer
package axi4_stream_upsizer_pkg;

    // How tuser is aggregated into each output beat.
    typedef enum logic [0:0] {
        TUSER_FIRST,
        TUSER_OR
    } tuser_mode_t;

    // Width of the lane counter for a given narrow/wide pair, never below one bit.
    function automatic int lane_cnt_width(input int slave_w, input int master_w);
        int ratio;
        ratio = master_w / slave_w;
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// rtl/axi4_stream_if.sv - AXI4-Stream bundle with master/slave views
//   tdata/tkeep/tstrb/tlast/tid/tdest/tuser/tvalid flow master->slave, tready slave->master
interface axi4_stream_if #(
    parameter int DATA_W = 32,
    parameter int ID_W   = 1,
    parameter int DEST_W = 1,
    parameter int USER_W = 1
);
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic [DATA_W/8-1:0] tstrb;
    logic                tlast;
    logic [ID_W-1:0]     tid;
    logic [DEST_W-1:0]   tdest;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tready;

    modport master (
        output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
        output tready
    );
endinterface

// File: rtl/axi4_stream_word_assembler.sv
// rtl/axi4_stream_word_assembler.sv - packs narrow beats into an open wide word and detects word close
//   clk_i/rst_i        : clock, asynchronous active-low reset
//   in_*               : narrow input beat; in_tready is the input ready
//   out_can_load       : output register can take a closed word this cycle
//   word_valid/word_*  : closed word presented for loading into the output register
module axi4_stream_word_assembler
    import axi4_stream_upsizer_pkg::*;
#(
    parameter int          SW          = 32,
    parameter int          MW          = 128,
    parameter int          IDW         = 1,
    parameter int          DSW         = 1,
    parameter int          UW          = 1,
    parameter tuser_mode_t TUSER_MODE  = TUSER_FIRST,
    parameter bit          FLUSH_ON_ID = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SW-1:0]     in_tdata,
    input  logic [SW/8-1:0]   in_tkeep,
    input  logic [SW/8-1:0]   in_tstrb,
    input  logic              in_tlast,
    input  logic [IDW-1:0]    in_tid,
    input  logic [DSW-1:0]    in_tdest,
    input  logic [UW-1:0]     in_tuser,
    input  logic              in_tvalid,
    output logic              in_tready,
    input  logic              out_can_load,
    output logic              word_valid,
    output logic [MW-1:0]     word_tdata,
    output logic [MW/8-1:0]   word_tkeep,
    output logic [MW/8-1:0]   word_tstrb,
    output logic              word_tlast,
    output logic [IDW-1:0]    word_tid,
    output logic [DSW-1:0]    word_tdest,
    output logic [UW-1:0]     word_tuser
);
    localparam int RATIO = MW / SW;
    localparam int LW    = lane_cnt_width(SW, MW);
    localparam int SB    = SW / 8;
    localparam int MB    = MW / 8;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [MW-1:0]  data_q,  data_d;
    logic [MB-1:0]  keep_q,  keep_d;
    logic [MB-1:0]  strb_q,  strb_d;
    logic [LW-1:0]  cnt_q,   cnt_d;
    logic [IDW-1:0] tid_q,   tid_d;
    logic [DSW-1:0] tdest_q, tdest_d;
    logic [UW-1:0]  tuser_q, tuser_d;
    logic           first_q, first_d;   // next accepted beat starts a packet

    logic           mismatch;
    logic           beat_closes;
    logic           accept;
    logic [MW-1:0]  merged_data;
    logic [MB-1:0]  merged_keep;
    logic [MB-1:0]  merged_strb;
    logic [UW-1:0]  merged_user;

    always_comb begin
        // A beat from a different stream may not join the open word; it waits
        // one cycle while the open word is pushed out.
        mismatch    = FLUSH_ON_ID && in_tvalid && (cnt_q != '0) &&
                      ((in_tid != tid_q) || (in_tdest != tdest_q));
        beat_closes = (cnt_q == LAST_LANE) || in_tlast;
        in_tready   = rst_i && !mismatch && !(beat_closes && !out_can_load);
        accept      = in_tvalid && in_tready;

        // Lane 0 starts from a cleared word so unfilled lanes read as zero.
        if (cnt_q == '0) begin
            merged_data = '0;
            merged_keep = '0;
            merged_strb = '0;
        end else begin
            merged_data = data_q;
            merged_keep = keep_q;
            merged_strb = strb_q;
        end
        merged_data[int'(cnt_q)*SW +: SW] = in_tdata;
        merged_keep[int'(cnt_q)*SB +: SB] = in_tkeep;
        merged_strb[int'(cnt_q)*SB +: SB] = in_tstrb;

        if (cnt_q == '0) begin
            merged_user = ((TUSER_MODE == TUSER_OR) || first_q) ? in_tuser : '0;
        end else if (TUSER_MODE == TUSER_OR) begin
            merged_user = tuser_q | in_tuser;
        end else begin
            merged_user = tuser_q;
        end

        data_d     = data_q;
        keep_d     = keep_q;
        strb_d     = strb_q;
        cnt_d      = cnt_q;
        tid_d      = tid_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;
        first_d    = first_q;
        word_valid = 1'b0;
        word_tdata = data_q;
        word_tkeep = keep_q;
        word_tstrb = strb_q;
        word_tlast = 1'b0;
        word_tid   = tid_q;
        word_tdest = tdest_q;
        word_tuser = tuser_q;

        if (accept) begin
            first_d = in_tlast;
            if (beat_closes) begin
                word_valid = 1'b1;
                word_tdata = merged_data;
                word_tkeep = merged_keep;
                word_tstrb = merged_strb;
                word_tlast = in_tlast;
                word_tid   = in_tid;
                word_tdest = in_tdest;
                word_tuser = merged_user;
                cnt_d      = '0;
            end else begin
                data_d  = merged_data;
                keep_d  = merged_keep;
                strb_d  = merged_strb;
                tid_d   = in_tid;
                tdest_d = in_tdest;
                tuser_d = merged_user;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (mismatch && out_can_load) begin
            // Flush: emit the registered word as-is with tlast low.
            word_valid = 1'b1;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            keep_q  <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            tid_q   <= '0;
            tdest_q <= '0;
            tuser_q <= '0;
            first_q <= 1'b1;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
            tid_q   <= tid_d;
            tdest_q <= tdest_d;
            tuser_q <= tuser_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/axi4_stream_packing_upsizer.sv
// rtl/axi4_stream_packing_upsizer.sv - AXI4-Stream upsizer packing narrow beats into wide beats
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   pkt_i : narrow slave stream (SLAVE_TDATA_WIDTH)
//   pkt_o : wide master stream (MASTER_TDATA_WIDTH), registered
module axi4_stream_packing_upsizer
    import axi4_stream_upsizer_pkg::*;
#(
    parameter int          SLAVE_TDATA_WIDTH  = 32,
    parameter int          MASTER_TDATA_WIDTH = 128,
    parameter int          TID_WIDTH          = 1,
    parameter int          TDEST_WIDTH        = 1,
    parameter int          TUSER_WIDTH        = 1,
    parameter tuser_mode_t TUSER_MODE         = TUSER_FIRST,
    parameter bit          FLUSH_ON_ID        = 1'b1
) (
    input logic           clk_i,
    input logic           rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int MW = MASTER_TDATA_WIDTH;
    localparam int MB = MASTER_TDATA_WIDTH / 8;

    if (((SLAVE_TDATA_WIDTH % 8) != 0) || ((MASTER_TDATA_WIDTH % 8) != 0) ||
        ((MASTER_TDATA_WIDTH % SLAVE_TDATA_WIDTH) != 0) ||
        ((MASTER_TDATA_WIDTH / SLAVE_TDATA_WIDTH) < 2)) begin : g_bad_width
        $fatal(1, "axi4_stream_packing_upsizer: widths must be byte multiples with integer ratio >= 2");
    end

    logic                   out_can_load;
    logic                   asm_tready;
    logic                   word_valid;
    logic [MW-1:0]          word_tdata;
    logic [MB-1:0]          word_tkeep;
    logic [MB-1:0]          word_tstrb;
    logic                   word_tlast;
    logic [TID_WIDTH-1:0]   word_tid;
    logic [TDEST_WIDTH-1:0] word_tdest;
    logic [TUSER_WIDTH-1:0] word_tuser;

    logic                   out_valid_q, out_valid_d;
    logic [MW-1:0]          out_data_q,  out_data_d;
    logic [MB-1:0]          out_keep_q,  out_keep_d;
    logic [MB-1:0]          out_strb_q,  out_strb_d;
    logic                   out_last_q,  out_last_d;
    logic [TID_WIDTH-1:0]   out_tid_q,   out_tid_d;
    logic [TDEST_WIDTH-1:0] out_tdest_q, out_tdest_d;
    logic [TUSER_WIDTH-1:0] out_tuser_q, out_tuser_d;

    axi4_stream_word_assembler #(
        .SW          (SLAVE_TDATA_WIDTH),
        .MW          (MASTER_TDATA_WIDTH),
        .IDW         (TID_WIDTH),
        .DSW         (TDEST_WIDTH),
        .UW          (TUSER_WIDTH),
        .TUSER_MODE  (TUSER_MODE),
        .FLUSH_ON_ID (FLUSH_ON_ID)
    ) u_assembler (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_tdata     (pkt_i.tdata),
        .in_tkeep     (pkt_i.tkeep),
        .in_tstrb     (pkt_i.tstrb),
        .in_tlast     (pkt_i.tlast),
        .in_tid       (pkt_i.tid),
        .in_tdest     (pkt_i.tdest),
        .in_tuser     (pkt_i.tuser),
        .in_tvalid    (pkt_i.tvalid),
        .in_tready    (asm_tready),
        .out_can_load (out_can_load),
        .word_valid   (word_valid),
        .word_tdata   (word_tdata),
        .word_tkeep   (word_tkeep),
        .word_tstrb   (word_tstrb),
        .word_tlast   (word_tlast),
        .word_tid     (word_tid),
        .word_tdest   (word_tdest),
        .word_tuser   (word_tuser)
    );

    always_comb begin
        // Empty or draining this cycle: a newly closed word can drop in without a gap.
        out_can_load = !out_valid_q || pkt_o.tready;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_strb_d  = out_strb_q;
        out_last_d  = out_last_q;
        out_tid_d   = out_tid_q;
        out_tdest_d = out_tdest_q;
        out_tuser_d = out_tuser_q;

        if (word_valid) begin
            out_valid_d = 1'b1;
            out_data_d  = word_tdata;
            out_keep_d  = word_tkeep;
            out_strb_d  = word_tstrb;
            out_last_d  = word_tlast;
            out_tid_d   = word_tid;
            out_tdest_d = word_tdest;
            out_tuser_d = word_tuser;
        end else if (pkt_o.tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_strb_q  <= '0;
            out_last_q  <= 1'b0;
            out_tid_q   <= '0;
            out_tdest_q <= '0;
            out_tuser_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_strb_q  <= out_strb_d;
            out_last_q  <= out_last_d;
            out_tid_q   <= out_tid_d;
            out_tdest_q <= out_tdest_d;
            out_tuser_q <= out_tuser_d;
        end
    end

    assign pkt_i.tready = asm_tready;
    assign pkt_o.tvalid = out_valid_q;
    assign pkt_o.tdata  = out_data_q;
    assign pkt_o.tkeep  = out_keep_q;
    assign pkt_o.tstrb  = out_strb_q;
    assign pkt_o.tlast  = out_last_q;
    assign pkt_o.tid    = out_tid_q;
    assign pkt_o.tdest  = out_tdest_q;
    assign pkt_o.tuser  = out_tuser_q;

endmodule

// File: tb/tb_axi4_stream_packing_upsizer.sv
// tb/tb_axi4_stream_packing_upsizer.sv - self-checking bench for the AXI4-Stream packing upsizer
module tb_axi4_stream_packing_upsizer;
    import axi4_stream_upsizer_pkg::*;

    localparam int SW    = 32;
    localparam int MW    = 128;
    localparam int RATIO = MW / SW;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  s;
        logic        l;
        logic        id;
        logic        de;
        logic        u;
        bit          first;
    } beat_t;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  k;
        logic [15:0]  s;
        logic         l;
        logic         id;
        logic         de;
        logic         uf;
        logic         uo;
    } word_t;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic o_ready = 1'b1;
    bit   rand_ready = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    beat_t open_q[$];
    word_t exp_q[$];
    word_t got_q[$];
    bit    next_first = 1'b1;

    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_W(SW)) s1 ();
    axi4_stream_if #(.DATA_W(SW)) s2 ();
    axi4_stream_if #(.DATA_W(MW)) m1 ();
    axi4_stream_if #(.DATA_W(MW)) m2 ();

    assign s2.tdata  = s1.tdata;
    assign s2.tkeep  = s1.tkeep;
    assign s2.tstrb  = s1.tstrb;
    assign s2.tlast  = s1.tlast;
    assign s2.tid    = s1.tid;
    assign s2.tdest  = s1.tdest;
    assign s2.tuser  = s1.tuser;
    assign s2.tvalid = s1.tvalid;
    assign m1.tready = o_ready;
    assign m2.tready = o_ready;

    axi4_stream_packing_upsizer #(.TUSER_MODE(TUSER_FIRST)) u_dut_first (
        .clk_i (clk),
        .rst_i (rst_i),
        .pkt_i (s1),
        .pkt_o (m1)
    );

    axi4_stream_packing_upsizer #(.TUSER_MODE(TUSER_OR)) u_dut_or (
        .clk_i (clk),
        .rst_i (rst_i),
        .pkt_i (s2),
        .pkt_o (m2)
    );

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Model: a word is the run of accepted beats ending at tlast, at RATIO beats,
    // or just before a beat from a different tid/tdest.
    function automatic void emit(input logic last);
        word_t w;
        w.d = '0; w.k = '0; w.s = '0; w.uo = 1'b0;
        foreach (open_q[i]) begin
            w.d[i*SW +: SW] = open_q[i].d;
            w.k[i*4 +: 4]   = open_q[i].k;
            w.s[i*4 +: 4]   = open_q[i].s;
            w.uo            = w.uo | open_q[i].u;
        end
        w.uf = open_q[0].first ? open_q[0].u : 1'b0;
        w.l  = last;
        w.id = open_q[0].id;
        w.de = open_q[0].de;
        exp_q.push_back(w);
        open_q.delete();
    endfunction

    function automatic void model_accept(input beat_t b_in);
        beat_t b;
        b = b_in;
        if (open_q.size() > 0 && (b.id != open_q[0].id || b.de != open_q[0].de))
            emit(1'b0);
        b.first    = next_first;
        next_first = b.l;
        open_q.push_back(b);
        if (b.l || open_q.size() == RATIO)
            emit(b.l);
    endfunction

    always @(posedge clk) begin
        #1;
        o_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    beat_t        mb;
    word_t        ew;
    word_t        gw;
    bit           stalled = 1'b0;
    logic [191:0] hold_sig;

    always @(negedge clk) begin
        if (!rst_i) begin
            stalled = 1'b0;
        end else begin
            if (s1.tvalid) begin
                if (s1.tready) begin
                    mb.d = s1.tdata; mb.k = s1.tkeep; mb.s = s1.tstrb; mb.l = s1.tlast;
                    mb.id = s1.tid; mb.de = s1.tdest; mb.u = s1.tuser; mb.first = 1'b0;
                    model_accept(mb);
                end else begin
                    stall_cnt++;
                end
            end
            if (stalled)
                chk("stall_stable", {m1.tvalid, m1.tdata, m1.tkeep, m1.tstrb, m1.tlast,
                                     m1.tid, m1.tdest, m1.tuser}, hold_sig);
            if (m1.tvalid && m1.tready) begin
                gw.d = m1.tdata; gw.k = m1.tkeep; gw.s = m1.tstrb; gw.l = m1.tlast;
                gw.id = m1.tid; gw.de = m1.tdest; gw.uf = m1.tuser; gw.uo = m2.tuser;
                got_q.push_back(gw);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %0h expected no beat", m1.tdata);
                end else begin
                    ew = exp_q.pop_front();
                    chk("out_tdata", m1.tdata, ew.d);
                    chk("out_tkeep", m1.tkeep, ew.k);
                    chk("out_tstrb", m1.tstrb, ew.s);
                    chk("out_tlast", m1.tlast, ew.l);
                    chk("out_tid", m1.tid, ew.id);
                    chk("out_tdest", m1.tdest, ew.de);
                    chk("out_tuser_first", m1.tuser, ew.uf);
                    chk("or_tvalid", m2.tvalid, 1'b1);
                    chk("or_tdata", m2.tdata, ew.d);
                    chk("out_tuser_or", m2.tuser, ew.uo);
                end
            end
            stalled  = m1.tvalid && !m1.tready;
            hold_sig = {m1.tvalid, m1.tdata, m1.tkeep, m1.tstrb, m1.tlast, m1.tid, m1.tdest, m1.tuser};
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic id,
                        input logic de, input logic u, input logic [3:0] k);
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        s1.tdata = d; s1.tkeep = k; s1.tstrb = k; s1.tlast = last;
        s1.tid = id; s1.tdest = de; s1.tuser = u; s1.tvalid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = s1.tready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no tready in %0d cycles expected acceptance", n);
                break;
            end
        end
        s1.tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m1.tvalid) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", n < 1000, 1'b1);
    endtask

    task automatic clear();
        got_q.delete();
        stall_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] n4;
        int         len;
        logic       rid;
        logic       rde;

        s1.tdata = '0; s1.tkeep = '0; s1.tstrb = '0; s1.tlast = 1'b0;
        s1.tid = '0; s1.tdest = '0; s1.tuser = '0; s1.tvalid = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {m1.tvalid, m1.tdata, m1.tkeep, m1.tstrb, m1.tlast,
                            m1.tid, m1.tdest, m1.tuser}, '0);
        chk("rst_tready", s1.tready, 1'b0);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("release_tready", s1.tready, 1'b1);

        // Eight full beats -> two wide beats, no stall
        clear();
        for (int i = 1; i <= 8; i++) begin
            n4 = i[3:0];
            send({8{n4}}, i == 8, 1'b0, 1'b0, 1'b0, 4'hF);
        end
        drain();
        chk("t1_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t1_w0_data", got_q[0].d, 128'h44444444_33333333_22222222_11111111);
            chk("t1_w0_keep_last", {got_q[0].k, got_q[0].l}, {16'hFFFF, 1'b0});
            chk("t1_w1_data", got_q[1].d, 128'h88888888_77777777_66666666_55555555);
            chk("t1_w1_keep_last", {got_q[1].k, got_q[1].l}, {16'hFFFF, 1'b1});
        end
        chk("t1_no_stall", stall_cnt, 0);

        // Three-beat packet -> partial word
        clear();
        send(32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        send(32'hBBBBBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        send(32'hCCCCCCCC, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
        drain();
        chk("t2_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("t2_keep", got_q[0].k, 16'h0FFF);
            chk("t2_top_lane", got_q[0].d[127:96], 32'h0);
            chk("t2_data", got_q[0].d, 128'h00000000_CCCCCCCC_BBBBBBBB_AAAAAAAA);
            chk("t2_last", got_q[0].l, 1'b1);
        end

        // tid change mid-word flushes the open word
        clear();
        send(32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        send(32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        send(32'h00000003, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        send(32'h00000004, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        send(32'h00000005, 1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
        send(32'h00000006, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
        drain();
        chk("t3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t3_w0", {got_q[0].id, got_q[0].k, got_q[0].l}, {1'b0, 16'h00FF, 1'b0});
            chk("t3_w1", {got_q[1].id, got_q[1].k, got_q[1].l}, {1'b1, 16'hFFFF, 1'b1});
            chk("t3_w0_data", got_q[0].d, 128'h00000002_00000001);
        end
        chk("t3_one_stall", stall_cnt, 1);

        // tuser aggregation, two 12-beat packets
        clear();
        for (int i = 0; i < 12; i++)
            send(32'h1000 + i, i == 11, 1'b0, 1'b0, i == 0, 4'hF);
        for (int i = 0; i < 12; i++)
            send(32'h2000 + i, i == 11, 1'b0, 1'b0, i == 5, 4'hF);
        drain();
        chk("t4_count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            chk("t4_first_mode_a", {got_q[0].uf, got_q[1].uf, got_q[2].uf}, 3'b100);
            chk("t4_or_mode_a", {got_q[0].uo, got_q[1].uo, got_q[2].uo}, 3'b100);
            chk("t4_first_mode_b", {got_q[3].uf, got_q[4].uf, got_q[5].uf}, 3'b000);
            chk("t4_or_mode_b", {got_q[3].uo, got_q[4].uo, got_q[5].uo}, 3'b010);
        end

        // Back-to-back single-beat packets
        clear();
        for (int i = 0; i < 4; i++)
            send(32'h5000 + i, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF);
        drain();
        chk("t5_count", got_q.size(), 4);
        if (got_q.size() == 4)
            chk("t5_keeps", {got_q[0].k, got_q[1].k, got_q[2].k, got_q[3].k}, {4{16'h000F}});
        chk("t5_no_stall", stall_cnt, 0);

        // Reset after two beats of a word
        clear();
        send(32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF);
        send(32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        rst_i = 1'b0;
        #1;
        chk("t6_rst_outputs", {m1.tvalid, m1.tdata, m1.tkeep, m1.tstrb, m1.tlast,
                               m1.tid, m1.tdest, m1.tuser}, '0);
        chk("t6_rst_tready", s1.tready, 1'b0);
        open_q.delete();
        exp_q.delete();
        next_first = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6_release_tready", s1.tready, 1'b1);
        clear();
        send(32'h01010101, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
        send(32'h02020202, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
        drain();
        chk("t6_count", got_q.size(), 1);
        if (got_q.size() == 1)
            chk("t6_word", {got_q[0].d, got_q[0].k}, {128'h02020202_01010101, 16'h00FF});

        // Random packets with output backpressure
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 20);
            rid = 1'($urandom_range(0, 1));
            rde = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 9) == 0) begin
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 19) == 0)
                    rid = ~rid;
                send($urandom, b == len - 1, rid, rde, 1'($urandom_range(0, 1)),
                     4'($urandom_range(1, 15)));
            end
        end
        rand_ready = 1'b0;
        drain();
        chk("rand_model_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_stream_packing_upsizer.md
# axi4_stream_packing_upsizer

AXI4-Stream width upsizer that packs RATIO narrow beats into one wide beat with full input throughput and independent output buffering. Partial words are closed at `tlast` and whenever `tid`/`tdest` changes mid-word. `tuser` is aggregated per output beat in a selectable mode. It sits between narrow-datapath producers (video/packet sources) and wide internal buses.

## Interface
- `SLAVE_TDATA_WIDTH`, 32: input data width in bits; multiple of 8.
- `MASTER_TDATA_WIDTH`, 128: output data width in bits; integer multiple of `SLAVE_TDATA_WIDTH`, ratio ≥ 2.
- `TID_WIDTH`, 1: width of `tid` on both sides.
- `TDEST_WIDTH`, 1: width of `tdest` on both sides.
- `TUSER_WIDTH`, 1: width of `tuser` on both sides.
- `TUSER_MODE`, `TUSER_FIRST`: `TUSER_FIRST` passes the packet's first-beat `tuser` on the first output beat and zero elsewhere; `TUSER_OR` gives the bitwise OR of all input `tuser` in the output word.
- `FLUSH_ON_ID`, 1: when 1, a `tid`/`tdest` change closes the open word.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  reset; asynchronous assert, active-low.
- `pkt_i`  slave `axi4_stream_if`  `SLAVE_TDATA_WIDTH` data  narrow input stream.
- `pkt_o`  master `axi4_stream_if`  `MASTER_TDATA_WIDTH` data  wide output stream.

## Operation
- RATIO = `MASTER_TDATA_WIDTH / SLAVE_TDATA_WIDTH`. Lane index = `ceil(log2(RATIO))` bits.
- Input beats fill lanes from the LSB, starting at lane 0: lane k holds `tdata[(k+1)*SW-1 -: SW]`.
- The assembly register holds the open word: data, keep, strb, lane count, tid, tdest, tuser accumulator.
- On the first lane of a word, the assembly register clears all lanes, so unfilled lanes read `tdata`/`tkeep`/`tstrb` = 0.
- A word closes on any of:
  - filling lane RATIO-1;
  - an accepted beat with `tlast`=1 (output `tlast`=1);
  - with `FLUSH_ON_ID`=1, an incoming valid beat whose `tid`/`tdest` differs from the open word's while lanes > 0.
- The flush case closes the open word with `tlast`=0 without consuming the incoming beat. That beat is accepted next cycle into lane 0.
- A closed word moves to the output register (`pkt_o`). `tid`/`tdest` come from the word's beats.
- `tuser`:
  - `TUSER_FIRST`: captured from the first beat after reset or after a `tlast`; 0 on later output beats of the packet.
  - `TUSER_OR`: accumulated, cleared at word start.
- Output register: `pkt_o.tvalid` is held until `pkt_o.tready`. Payload stays stable while stalled.
- `pkt_i.tready` = !(assembly would close this cycle && output register full && !`pkt_o.tready`) && !flush_pending.
- Reset value of every output: `tvalid`, `tdata`, `tkeep`, `tstrb`, `tlast`, `tuser`, `tid`, `tdest` = 0; `pkt_i.tready` = 0 during reset, 1 in the first cycle after release.
- Reset mid-word discards partial data. No beat is emitted for it.

## Timing
- Latency: the output beat is valid 1 cycle after the input handshake that closes it. A flush emits 1 cycle after the mismatching beat is presented.
- Throughput: 1 input beat per cycle sustained with `pkt_o.tready`=1. No bubble between words or packets.
- Simultaneous close and output handshake in the same cycle: the new word loads the output register with no gap.
- Stall: with the output register full and `pkt_o.tready`=0, input is still accepted until the assembly register would close.
- Back-to-back single-beat packets, each `tlast`=1: one output beat per cycle.

## Structure
- Package `axi4_stream_upsizer_pkg`:
  - enum `tuser_mode_t` {`TUSER_FIRST`, `TUSER_OR`};
  - function computing the lane-counter width from the two data widths.
- Sub-module `axi4_stream_word_assembler`: lane counter, assembly register, close/flush detection, `tuser` accumulation. The top level adds the output register and ready logic.
- Elaboration-time check: fatal if the width ratio is not an integer ≥ 2, or the data widths are not byte multiples.

## Test plan
- 32→128, 8 beats 0x11111111..0x88888888, `tlast` on beat 8, ready=1 → two beats 0x44444444_33333333_22222222_11111111 and 0x888...555 (`tlast`=1), `tkeep`=0xFFFF, no input stall.
- 3-beat packet, `tlast` on beat 3 → one beat with `tkeep`=0x0FFF, `tdata[127:96]`=0, `tlast`=1.
- `tid` 0,0 then 1,1,1,1 with `tlast`, `FLUSH_ON_ID`=1 → beat 1 has `tid`=0, `tkeep`=0x00FF, `tlast`=0; beat 2 has `tid`=1, `tkeep`=0xFFFF; input `tready` low exactly 1 cycle.
- `pkt_o.tready` random 30%, 1000 random packets of length 1–20 → output matches the reference model; payload stable while valid && !ready.
- `TUSER_FIRST`, `tuser`=1 on first input beat only, 12-beat packet → `tuser` 1,0,0 on the three output beats. `TUSER_OR` with `tuser` on beat 6 → `tuser` 0,1,0.
- Assert `rst_i` low after 2 beats of a word → all outputs 0 immediately; after release, next packet starts at lane 0 and no partial word is emitted.
